bp_update_queue: RTL and testbench

In-order branch-resolution queue that drives the update port of the bimodal branch predictor. Fetch pushes each predicted branch (PC, predicted direction, predicted target) when it issues a lookup. Execute resolves branches oldest-first. The queue emits one registered predictor update per resolved branch and raises a one-cycle mispredict/redirect to fetch when the prediction was wrong.

---
 rtl/bp_update_queue.sv | 145 ++++++++++++++
 tb/tb_bp_update_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_queue.sv
// In-order branch-resolution queue feeding the bimodal predictor update port.
// Fetch pushes predicted branches, execute resolves them oldest-first. Each
// resolve produces one registered update pulse and, on a wrong prediction,
// a coincident mispredict/redirect that also discards all younger entries.
//
// Handshake: a push is accepted in any cycle where enq_valid && enq_ready are
// both high at the rising edge (unless a flush or a mispredicting resolve
// drops it). enq_ready depends only on registered occupancy, never on
// enq_valid. resolve_valid has no ready; it is accepted whenever the queue is
// non-empty and no flush is present.
module bp_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [31:0]              enq_pc,
    input  logic                     enq_prediction,
    input  logic [31:0]              enq_target,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic [31:0]              resolve_target,
    input  logic                     flush,
    output logic                     update_valid,
    output logic [31:0]              update_pc,
    output logic                     update_prediction,
    output logic                     update_actual,
    output logic [31:0]              update_target,
    output logic                     mispredict,
    output logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     resolve_err,
    output logic [CNT_W-1:0]         stat_updates,
    output logic [CNT_W-1:0]         stat_mispredicts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [31:0]      pc_mem   [DEPTH];
    logic             pred_mem [DEPTH];
    logic [31:0]      tgt_mem  [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic             not_empty;
    logic             do_resolve;
    logic             do_enq;
    logic             head_pred;
    logic [31:0]      head_pc;
    logic [31:0]      head_tgt;
    logic             wrong;

    assign enq_ready = (count != CW'(DEPTH));
    assign not_empty = (count != '0);

    assign head_pc   = pc_mem[head];
    assign head_pred = pred_mem[head];
    assign head_tgt  = tgt_mem[head];

    // A resolve is wrong on direction, or on target when both say taken.
    assign wrong = (head_pred != resolve_taken) ||
                   (head_pred && resolve_taken && (head_tgt != resolve_target));

    // Flush beats resolve beats enqueue; a mispredicting resolve drops the push.
    assign do_resolve = !flush && resolve_valid && not_empty;
    assign do_enq     = !flush && enq_valid && enq_ready && !(do_resolve && wrong);

    // Entry storage is deliberately not reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            pc_mem[tail]   <= enq_pc;
            pred_mem[tail] <= enq_prediction;
            tgt_mem[tail]  <= enq_target;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush || (do_resolve && wrong)) begin
            // Tail stays put: the dropped push never advanced it.
            head  <= tail;
            count <= '0;
        end else begin
            if (do_resolve) head <= head + PTR_W'(1);
            if (do_enq)     tail <= tail + PTR_W'(1);
            case ({do_enq, do_resolve})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered update/redirect outputs, one cycle after the resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_valid      <= 1'b0;
            update_pc         <= '0;
            update_prediction <= 1'b0;
            update_actual     <= 1'b0;
            update_target     <= '0;
            mispredict        <= 1'b0;
            redirect_pc       <= '0;
        end else begin
            update_valid <= do_resolve;
            mispredict   <= do_resolve && wrong;
            if (do_resolve) begin
                update_pc         <= head_pc;
                update_prediction <= head_pred;
                update_actual     <= resolve_taken;
                update_target     <= resolve_taken ? resolve_target : 32'd0;
                redirect_pc       <= resolve_taken ? resolve_target : head_pc + 32'd4;
            end
        end
    end

    // Sticky error for resolves that arrive with nothing outstanding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolve_err <= 1'b0;
        end else if (!flush && resolve_valid && !not_empty) begin
            resolve_err <= 1'b1;
        end
    end

    // Free-running statistics, wrapping naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_updates     <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (do_resolve)          stat_updates     <= stat_updates + CNT_W'(1);
            if (do_resolve && wrong) stat_mispredicts <= stat_mispredicts + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bp_update_queue.sv
// Bench for bp_update_queue: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_bp_update_queue;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic        clk;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic        enq_prediction;
  logic [31:0] enq_target;
  logic        resolve_valid;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        flush;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_prediction;
  logic        update_actual;
  logic [31:0] update_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
  logic        resolve_err;
  logic [CNT_W-1:0] stat_updates;
  logic [CNT_W-1:0] stat_mispredicts;

  bp_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_prediction(enq_prediction), .enq_target(enq_target),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .resolve_target(resolve_target), .flush(flush),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_prediction(update_prediction), .update_actual(update_actual),
    .update_target(update_target), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .count(count), .resolve_err(resolve_err),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  // Outstanding branches, oldest first: {pc[64:33], pred[32], target[31:0]}
  logic [64:0] exp_q[$];
  logic        exp_err;
  logic [31:0] exp_upd;
  logic [31:0] exp_mis;

  logic        e_uv, e_mis, e_pred, e_act;
  logic [31:0] e_pc, e_tgt, e_redir;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_err = 1'b0;
    exp_upd = 32'd0;
    exp_mis = 32'd0;
  endtask

  // ---------------- driver: one clock cycle of stimulus ----------------
  task automatic cycle(input logic ev, input logic [31:0] pc, input logic pred,
                       input logic [31:0] tgt, input logic rv, input logic rt,
                       input logic [31:0] rtg, input logic fl);
    logic        full;
    logic [64:0] ent;
    enq_valid      = ev;
    enq_pc         = pc;
    enq_prediction = pred;
    enq_target     = tgt;
    resolve_valid  = rv;
    resolve_taken  = rt;
    resolve_target = rtg;
    flush          = fl;
    @(negedge clk);
    check("enq_ready", {31'd0, enq_ready}, {31'd0, exp_q.size() != DEPTH});
    full  = (exp_q.size() == DEPTH);
    e_uv  = 1'b0;
    e_mis = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (rv) begin
        if (exp_q.size() == 0) begin
          exp_err = 1'b1;
        end else begin
          ent     = exp_q.pop_front();
          e_uv    = 1'b1;
          e_pc    = ent[64:33];
          e_pred  = ent[32];
          e_act   = rt;
          e_tgt   = rt ? rtg : 32'd0;
          e_mis   = (e_pred != rt) || (e_pred && rt && ent[31:0] != rtg);
          e_redir = rt ? rtg : e_pc + 32'd4;
          exp_upd = exp_upd + 32'd1;
          if (e_mis) begin
            exp_mis = exp_mis + 32'd1;
            exp_q.delete();
          end
        end
      end
      if (ev && !full && !e_mis) exp_q.push_back({pc, pred, tgt});
    end
    @(posedge clk);
    #1;
    check("update_valid", {31'd0, update_valid}, {31'd0, e_uv});
    check("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
    if (e_uv) begin
      check("update_pc", update_pc, e_pc);
      check("update_prediction", {31'd0, update_prediction}, {31'd0, e_pred});
      check("update_actual", {31'd0, update_actual}, {31'd0, e_act});
      check("update_target", update_target, e_tgt);
    end
    if (e_mis) check("redirect_pc", redirect_pc, e_redir);
    check("count", {28'd0, count}, exp_q.size());
    check("resolve_err", {31'd0, resolve_err}, {31'd0, exp_err});
    check("stat_updates", stat_updates, exp_upd);
    check("stat_mispredicts", stat_mispredicts, exp_mis);
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred, input logic [31:0] tgt);
    cycle(1'b1, pc, pred, tgt, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic res(input logic rt, input logic [31:0] rtg);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, rt, rtg, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_update_valid"}, {31'd0, update_valid}, 32'd0);
    check({tag, "_update_pc"}, update_pc, 32'd0);
    check({tag, "_update_target"}, update_target, 32'd0);
    check({tag, "_update_actual"}, {31'd0, update_actual}, 32'd0);
    check({tag, "_mispredict"}, {31'd0, mispredict}, 32'd0);
    check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    check({tag, "_count"}, {28'd0, count}, 32'd0);
    check({tag, "_resolve_err"}, {31'd0, resolve_err}, 32'd0);
    check({tag, "_stat_updates"}, stat_updates, 32'd0);
    check({tag, "_stat_mispredicts"}, stat_mispredicts, 32'd0);
    check({tag, "_enq_ready"}, {31'd0, enq_ready}, 32'd1);
  endtask

  // One randomized cycle; resolves are mostly correct so the queue fills.
  task automatic random_cycle();
    logic        ev, pred, rv, rt, fl;
    logic [31:0] pc, tgt, rtg;
    logic [64:0] hd;
    ev   = ($urandom_range(0, 99) < 60);
    pc   = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
    pred = $urandom_range(0, 1);
    tgt  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10;
    rv   = (exp_q.size() > 0) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 2);
    rt   = $urandom_range(0, 1);
    rtg  = 32'h1000 + 32'($urandom_range(0, 3)) * 32'h10;
    if (exp_q.size() > 0 && $urandom_range(0, 99) < 80) begin
      hd  = exp_q[0];
      rt  = hd[32];
      rtg = hd[32] ? hd[31:0] : rtg;
    end
    fl = ($urandom_range(0, 99) < 2);
    cycle(ev, pc, pred, tgt, rv, rt, rtg, fl);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    enq_valid = 1'b0; enq_pc = '0; enq_prediction = 1'b0; enq_target = '0;
    resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_target = '0; flush = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Correct not-taken
    enq(32'h100, 1'b0, 32'h0);
    res(1'b0, 32'h0);
    check("nt_update_pc", update_pc, 32'h100);
    check("nt_stat_updates", stat_updates, 32'd1);

    // Target mismatch: younger entry discarded
    enq(32'h200, 1'b1, 32'h400);
    enq(32'h204, 1'b0, 32'h0);
    res(1'b1, 32'h480);
    check("tm_redirect", redirect_pc, 32'h480);
    check("tm_count", {28'd0, count}, 32'd0);
    idle();

    // Direction mispredict with PC wrap
    enq(32'hFFFF_FFFC, 1'b1, 32'h10);
    res(1'b0, 32'h0);
    check("wrap_redirect", redirect_pc, 32'h0);
    check("wrap_stat_mis", stat_mispredicts, 32'd2);

    // Full queue, refused 9th offer, FIFO order, then pointer wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH + 1; i++) enq(32'h3000 + 32'(r * 64 + i * 4), 1'b0, 32'h0);
      for (int i = 0; i < DEPTH; i++) res(1'b0, 32'h0);
      idle();
    end

    // Flush against resolve and enqueue
    for (int i = 0; i < 3; i++) enq(32'h500 + 32'(i * 4), 1'b1, 32'h600);
    cycle(1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 1'b1);
    idle();

    // Resolve while empty -> sticky error
    res(1'b0, 32'h0);
    idle();
    enq(32'h800, 1'b0, 32'h0);
    res(1'b0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) random_cycle();

    // Async reset mid-stream with 5 entries and an update in flight
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 6; i++) enq(32'h900 + 32'(i * 4), 1'b0, 32'h0);
    res(1'b0, 32'h0);
    check("pre_rst_update_valid", {31'd0, update_valid}, 32'd1);
    check("pre_rst_count", {28'd0, count}, 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    rst = 1'b0;
    model_clear();
    idle();
    enq(32'hA00, 1'b1, 32'hB00);
    res(1'b1, 32'hB00);
    check("post_rst_pc", update_pc, 32'hA00);

    for (int i = 0; i < 300; i++) random_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
